// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: streams one bank of weights from a 1-cycle-latency BRAM
// through a 2-entry skid FIFO onto a valid/ready stream.
module weight_fetch_ctrl #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr,
    output logic          en,
    output logic          we,
    output logic [DW-1:0] di,
    input  logic [DW-1:0] bram_do,
    output logic [DW-1:0] w_data,
    output logic [AW-1:0] w_idx,
    output logic          w_last,
    output logic          w_valid,
    input  logic          w_ready
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] fifo_data [2];
    logic [AW-1:0] fifo_idx  [2];
    logic [1:0]    fifo_last;
    logic          wr_sel;
    logic          rd_sel;
    logic [1:0]    fifo_count;
    logic          fifo_empty;
    logic          pop;
    logic          issue;
    logic          load_ptr;

    assign fifo_empty = (fifo_count == 2'd0);
    assign pop        = w_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A read is issued only if its data is guaranteed a FIFO slot when it lands.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        load_ptr   = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = FETCH;
                    load_ptr   = 1'b1;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                end else if ({1'b0, fifo_count} <= 3'd1 + {2'b00, pop}) begin
                    issue = 1'b1;
                    if (ptr == LAST_ADDR) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    busy       = 1'b1;
                    next_state = IDLE;
                end else if (fifo_empty) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign en   = issue;
    assign addr = issue ? ptr : addr_q;
    assign we   = 1'b0;
    assign di   = '0;

    // The pointer saturates at the last address so it can never wrap within a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            addr_q <= '0;
        end else begin
            if (load_ptr) begin
                ptr <= '0;
            end else if (issue && (ptr != LAST_ADDR)) begin
                ptr <= ptr + 1'b1;
            end
            if (issue) begin
                addr_q <= ptr;
            end
        end
    end

    // BRAM data from an issue cycle is valid at the following rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
            fifo_last  <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            fifo_count <= 2'd0;
        end else if (abort) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (issue) begin
                fifo_data[wr_sel] <= bram_do;
                fifo_idx[wr_sel]  <= ptr;
                fifo_last[wr_sel] <= (ptr == LAST_ADDR);
                wr_sel            <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({issue, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign w_valid = !fifo_empty;
    assign w_data  = w_valid ? fifo_data[rd_sel] : '0;
    assign w_idx   = w_valid ? fifo_idx[rd_sel] : '0;
    assign w_last  = w_valid ? fifo_last[rd_sel] : 1'b0;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: stimulus queues expected beats, a negedge
// monitor pops and compares every transferred beat and checks DONE placement.
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          w_ready;
    logic          busy;
    logic          done;
    logic          en;
    logic          we;
    logic          w_last;
    logic          w_valid;
    logic [AW-1:0] addr;
    logic [AW-1:0] w_idx;
    logic [DW-1:0] di;
    logic [DW-1:0] bram_do = '0;
    logic [DW-1:0] w_data;
    logic [DW-1:0] mem [DEPTH];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         exp_b;
    int            checks     = 0;
    int            errors     = 0;
    int            beat_total = 0;
    int            en_total   = 0;
    int            done_total = 0;
    int            occ        = 0;
    int            max_occ    = 0;
    logic          xfer;
    logic          prev_last_xfer = 1'b0;
    logic [AW-1:0] last_en_addr   = '0;
    int            bb;
    int            be;
    int            bd;

    weight_fetch_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .addr   (addr),
        .en     (en),
        .we     (we),
        .di     (di),
        .bram_do(bram_do),
        .w_data (w_data),
        .w_idx  (w_idx),
        .w_last (w_last),
        .w_valid(w_valid),
        .w_ready(w_ready)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 16'h0100 + 16'(i);
        end
    end

    always @(negedge clk) begin
        if (en) begin
            bram_do <= mem[addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: a beat transfers at the next rising edge when valid, ready and no abort.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ            = 0;
            prev_last_xfer = 1'b0;
        end else begin
            xfer = w_valid && w_ready && !abort;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got data=0x%0h idx=%0d, required no beat", w_data, w_idx);
                end else begin
                    exp_b = exp_q.pop_front();
                    checkOutput("beat_data", 32'(w_data), 32'(exp_b.data));
                    checkOutput("beat_idx", 32'(w_idx), 32'(exp_b.idx));
                    checkOutput("beat_last", 32'(w_last), 32'(exp_b.last));
                end
                beat_total++;
            end
            if (done) begin
                checkOutput("done_after_last_beat", 32'(prev_last_xfer), 1);
                checkOutput("busy_low_with_done", 32'(busy), 0);
                checkOutput("queue_empty_at_done", 32'(exp_q.size()), 0);
                done_total++;
            end
            if (en) begin
                en_total++;
                last_en_addr = addr;
            end
            prev_last_xfer = xfer && w_last;
            occ = abort ? 0 : occ + int'(en) - int'(xfer);
            if (occ > max_occ) begin
                max_occ = occ;
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        @(posedge clk);
        #1;
        start   = s;
        abort   = a;
        w_ready = r;
    endtask

    task automatic snapshot();
        bb = beat_total;
        be = en_total;
        bd = done_total;
    endtask

    // Queues the full expected bank, pulses START and checks the first issue and beat.
    task automatic startRun(input logic r);
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.data = 16'h0100 + 16'(i);
            b.idx  = AW'(i);
            b.last = (i == DEPTH - 1);
            exp_q.push_back(b);
        end
        applyStimulus(1'b1, 1'b0, r);
        applyStimulus(1'b0, 1'b0, r);
        @(negedge clk);
        checkOutput("first_en", 32'(en), 1);
        checkOutput("first_addr", 32'(addr), 0);
        @(negedge clk);
        checkOutput("first_valid", 32'(w_valid), 1);
        checkOutput("first_data", 32'(w_data), 32'h0100);
    endtask

    task automatic endRun(input string name);
        for (int i = 0; i < 400 && done_total == bd; i++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        checkOutput({name, "_done_count"}, 32'(done_total - bd), 1);
        checkOutput({name, "_beats"}, 32'(beat_total - bb), 28);
        checkOutput({name, "_en_count"}, 32'(en_total - be), 28);
        checkOutput({name, "_busy_idle"}, 32'(busy), 0);
    endtask

    task automatic waitBeats(input int n);
        for (int i = 0; i < 200 && (beat_total - bb) < n; i++) begin
            @(posedge clk);
        end
        checkOutput("beats_reached", 32'((beat_total - bb) >= n), 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        w_ready = 1'b0;
        #3;
        checkOutput("reset_ctrl", 32'({busy, done, en, we, w_last, w_valid}), 0);
        checkOutput("reset_addr_idx", 32'({addr, w_idx}), 0);
        checkOutput("reset_data", 32'({di, w_data}), 0);
        #20;
        rst_n = 1'b1;

        $display("[TB] basic run, ready high");
        snapshot();
        startRun(1'b1);
        endRun("A");

        $display("[TB] ready low from start");
        snapshot();
        startRun(1'b0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("B_en_stalled", 32'(en_total - be), 2);
        checkOutput("B_last_addr", 32'(last_en_addr), 1);
        checkOutput("B_hold_valid", 32'(w_valid), 1);
        checkOutput("B_hold_data", 32'(w_data), 32'h0100);
        applyStimulus(1'b0, 1'b0, 1'b1);
        endRun("B");

        $display("[TB] ready toggling");
        snapshot();
        startRun(1'b1);
        for (int i = 0; i < 400 && done_total == bd; i++) begin
            applyStimulus(1'b0, 1'b0, ~w_ready);
        end
        w_ready = 1'b1;
        endRun("C");
        checkOutput("C_fifo_max_le2", 32'(max_occ <= 2), 1);

        $display("[TB] start repeated mid-run");
        snapshot();
        startRun(1'b1);
        waitBeats(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("D_busy", 32'(busy), 1);
        endRun("D");

        $display("[TB] abort mid-run");
        snapshot();
        startRun(1'b1);
        waitBeats(10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        exp_q.delete();
        @(negedge clk);
        checkOutput("E_busy_after_abort", 32'(busy), 0);
        checkOutput("E_valid_after_abort", 32'(w_valid), 0);
        repeat (4) @(posedge clk);
        checkOutput("E_no_done", 32'(done_total - bd), 0);
        snapshot();
        startRun(1'b1);
        endRun("E");

        $display("[TB] async reset mid-fetch");
        snapshot();
        startRun(1'b1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("F_reset_ctrl", 32'({busy, done, en, we, w_last, w_valid}), 0);
        checkOutput("F_reset_addr_idx", 32'({addr, w_idx}), 0);
        checkOutput("F_reset_data", 32'({di, w_data}), 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        snapshot();
        startRun(1'b1);
        endRun("F");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

endmodule
